// File: rtl/hex2seg_scan.sv
// Multiplexed hex display scanner: prescaled digit scan, frame-synchronous shadow->active update.
// Optional blink support is enabled by defining HEX2SEG_BLINK_EN.
module hex2seg_scan #(
  parameter int unsigned NDIG      = 8,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4*NDIG-1:0] data,
  input  logic [NDIG-1:0]   dp,
`ifdef HEX2SEG_BLINK_EN
  input  logic [NDIG-1:0]   blink,
`endif
  input  logic              load,
  input  logic              lz_en,
  output logic [7:0]        seg,
  output logic [NDIG-1:0]   an
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  if (NDIG < 1 || NDIG > 16 || SCAN_DIV < 1 || BLINK_DIV < 1) begin : g_bad_param
    $error("hex2seg_scan: parameter out of range");
  end

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic              tick;
  logic              frame_end;
  logic [4*NDIG-1:0] sh_data, act_data;
  logic [NDIG-1:0]   sh_dp, act_dp;
  logic              pending;

  assign tick      = (cnt == CNT_LAST);
  assign frame_end = tick && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // A load on the boundary edge still captures into shadow and keeps pending set;
  // active takes the previous shadow contents on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_data  <= '0;
      sh_dp    <= '0;
      act_data <= '0;
      act_dp   <= '0;
      pending  <= 1'b0;
    end else begin
      if (frame_end && pending) begin
        act_data <= sh_data;
        act_dp   <= sh_dp;
      end
      if (load) begin
        sh_data <= data;
        sh_dp   <= dp;
        pending <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef HEX2SEG_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] FRM_LAST = BW'(BLINK_DIV - 1);

  logic [NDIG-1:0] sh_blink, act_blink;
  logic [BW-1:0]   fcnt;
  logic            phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_blink  <= '0;
      act_blink <= '0;
      fcnt      <= '0;
      phase     <= 1'b0;
    end else begin
      if (load) sh_blink <= blink;
      if (frame_end && pending) act_blink <= sh_blink;
      if (frame_end) begin
        if (fcnt == FRM_LAST) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end
`endif

  logic [3:0]      nib;
  logic [6:0]      code;
  logic [NDIG-1:0] zero_up;
  logic            hi_zero;
  logic [7:0]      seg_next;
  logic [NDIG-1:0] an_next;

  always_comb begin
    hi_zero = 1'b1;
    zero_up = '0;
    // zero_up[i]: digit i and every higher digit of the active value are zero
    for (int unsigned j = 0; j < NDIG; j++) begin
      hi_zero = hi_zero & (act_data[4*(NDIG-1-j) +: 4] == 4'h0);
      zero_up[NDIG-1-j] = hi_zero;
    end
    nib = act_data[4*idx +: 4];
    case (nib)
      4'h0: code = 7'h3F;
      4'h1: code = 7'h06;
      4'h2: code = 7'h5B;
      4'h3: code = 7'h4F;
      4'h4: code = 7'h66;
      4'h5: code = 7'h6D;
      4'h6: code = 7'h7D;
      4'h7: code = 7'h07;
      4'h8: code = 7'h7F;
      4'h9: code = 7'h67;
      4'hA: code = 7'h77;
      4'hB: code = 7'h7C;
      4'hC: code = 7'h39;
      4'hD: code = 7'h5E;
      4'hE: code = 7'h79;
      default: code = 7'h71;
    endcase
    if (lz_en && (idx != '0) && zero_up[idx]) code = '0;
    seg_next = ~{act_dp[idx], code};
`ifdef HEX2SEG_BLINK_EN
    if (phase && act_blink[idx]) seg_next = '1;
`endif
    an_next = ~(NDIG'(1) << idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= '1;
      an  <= '1;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: doc/hex2seg_scan.md
HEX2SEG_SCAN -- requirements
Module: hex2seg_scan

Interface
REQ-001 Parameter NDIG, default 8, number of multiplexed digits (1..16).
REQ-002 Parameter SCAN_DIV, default 50000, clock cycles per digit slot (>=1).
REQ-003 Parameter BLINK_DIV, default 25, scan frames per blink half-period (>=1).
REQ-004 Clk  input  1  system clock, rising-edge active.
REQ-005 Rst_n  input  1  asynchronous active-low reset.
REQ-006 Data  input  4*NDIG  hex nibbles; Data[4i+3:4i] is digit i, digit 0 least significant.
REQ-007 Dp  input  NDIG  decimal point request per digit, 1 = lit.
REQ-008 Load  input  1  single-cycle strobe capturing Data, Dp (and Blink) into the shadow register.
REQ-009 Lz_en  input  1  leading-zero blanking enable, sampled every cycle.
REQ-010 seg  output  8  registered, active-low segments; bit7 = dp, bits 6:0 = g..a.
REQ-011 an  output  NDIG  registered, active-low digit enables, one-hot-low.

Function
REQ-012 Prescaler counts 0..SCAN_DIV-1 and wraps; the cycle at SCAN_DIV-1 is a tick.
REQ-013 On each tick the digit index advances by 1 modulo NDIG; index wrap from NDIG-1 to 0 is a frame boundary.
REQ-014 seg and an are registered from the current index and active register; both change together exactly one cycle after the index changes.
REQ-015 an[idx]=0, all other an bits 1.
REQ-016 Segment encoding (bits 6:0 before inversion): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=67 A=77 B=7C C=39 D=5E E=79 F=71; seg = ~{dp,code}.
REQ-017 Load=1 captures inputs into the shadow register at that edge and sets a pending flag.
REQ-018 Shadow is copied into the active register only at a frame boundary when pending=1; pending then clears; no digit ever shows a mix of old and new values within a frame.
REQ-019 Multiple Loads before a boundary: last captured value wins.
REQ-020 Load coincident with a frame boundary: the newly captured value is held in shadow and applied at the next boundary; pending remains set.
REQ-021 NDIG=1: every tick is a frame boundary.
REQ-022 Lz_en=1: digit i>0 has segments 6:0 blanked (1) when it and all higher digits of the active value are 0; digit 0 never blanked; dp still follows Dp.

Reset
REQ-023 Rst_n low asynchronously sets prescaler=0, index=0, shadow=0, active=0, pending=0, seg=8'hFF, an=all ones.
REQ-024 Reset mid-frame discards any pending Load; after release the first tick occurs SCAN_DIV cycles later, showing active value 0.

Configuration
REQ-025 Macro HEX2SEG_BLINK_EN defined: input Blink [NDIG-1:0] exists, captured with Load like Dp; a frame counter toggles a blink phase every BLINK_DIV frames; phase=1 forces seg=8'hFF for digits with Blink=1; phase resets to 0.
REQ-026 Macro undefined: no Blink port, no frame counter, no blink behaviour.

Verification
REQ-027 NDIG=4, SCAN_DIV=4, Load Data=16'h1A3F, Dp=0 -> after next boundary, frame shows an 1110/1101/1011/0111 with seg 8E/B0/88/F9, each slot 4 cycles.
REQ-028 Load 16'h1234 then 16'h5678 in the same frame -> next frame shows only 5678, never 1234.
REQ-029 Lz_en=1, Data=16'h0050 -> digits 3,2 seg=FF, digit 1=92, digit 0=C0; Data=0 -> only digit 0 shows C0.
REQ-030 Rst_n pulsed low mid-frame with pending Load -> seg=FF, an=1111 immediately; after release display shows 0s, pending value lost.
REQ-031 HEX2SEG_BLINK_EN, BLINK_DIV=2, Blink=4'b0001 -> digit 0 dark for frames 2-3, lit for 0-1 and 4-5; other digits always lit.
